core_pattern_player: RTL
========================

# core_pattern_player

Synthesizable, parametrised pattern player and checker for the HW3 `core` datapath, for FPGA/emulation bring-up where no simulator testbench exists. It replays an op-mode list into the core's op handshake and streams an input feature map on each load op. It checks the output stream against golden words, then reports pass/fail, error count, first failing index, cycle count and timeout. Sits between three synchronous pattern ROMs and the core under test.

## Interface
- `DATA_W`, 8: input feature byte width
- `OP_W`, 4: op-mode width
- `OUT_W`, 14: core output width
- `LOAD_MODE`, 0: op-mode value that triggers an input stream
- `LOAD_LEN`, 2048: beats streamed per load op
- `OP_DEPTH`, 1024: op ROM depth
- `GOLD_DEPTH`, 4096: golden ROM depth
- `MAX_CYCLE`, 4000: timeout, in cycles after start
- `i_clk`  in  1  clock
- `i_rst`  in  1  reset, synchronous, active-high
- `i_start`  in  1  one-cycle run request; ignored while `o_busy`
- `i_op_count`  in  clog2(OP_DEPTH+1)  ops to issue
- `i_gold_count`  in  clog2(GOLD_DEPTH+1)  golden words expected
- `o_op_addr`/`i_op_rdata`  out/in  clog2(OP_DEPTH)/OP_W  op ROM port
- `o_in_addr`/`i_in_rdata`  out/in  clog2(LOAD_LEN)/DATA_W  input ROM port
- `o_gold_addr`/`i_gold_rdata`  out/in  clog2(GOLD_DEPTH)/OUT_W  golden ROM port
- `o_op_valid`, `o_op_mode`  out  1, OP_W  op issue to core
- `i_op_ready`  in  1  core ready for op
- `o_in_valid`, `o_in_data`  out  1, DATA_W  feature stream
- `i_in_ready`  in  1  core accepts beat
- `i_out_valid`, `i_out_data`  in  1, OUT_W  core result
- `o_busy`, `o_done`, `o_pass`, `o_timeout`  out  1  status; `o_done` is sticky until next start
- `o_err_cnt`  out  16  mismatches plus overflow words, saturating
- `o_first_err`  out  clog2(GOLD_DEPTH+1)  index of first error; all-ones if none
- `o_cycle_cnt`  out  32  cycles from start to done

## Operation
- All ROMs are 1-cycle synchronous: data seen at cycle t belongs to the address driven at t-1.
- Addresses are driven from next-state indices, so the current word is always present. This sustains 1 beat/cycle with no prefetch buffer.
- Issue FSM:
  - IDLE: on `i_start`, clear all status and go to FETCH.
  - FETCH: one cycle for `i_op_rdata` to become valid.
  - WAIT_RDY: wait for `i_op_ready`.
  - ISSUE: `o_op_valid`=1 for exactly one cycle, `o_op_mode`=op[i].
    - If mode==LOAD_MODE, go to LOAD; else go to NEXT.
  - LOAD: `o_in_valid`=1 with `o_in_data`=in[j]. A beat transfers when `o_in_valid&&i_in_ready`, then j++. After beat LOAD_LEN-1, go to NEXT.
  - NEXT: i++. If i==`i_op_count`, go to DRAIN; else go to FETCH.
  - DRAIN: wait until k==`i_gold_count`, then go to DONE.
  - DONE: go to IDLE.
- Checker runs concurrently from start until done. Each cycle with `i_out_valid`:
  - If k<`i_gold_count`: compare with gold[k]. On mismatch, increment the error count and latch `o_first_err` if unset. k++.
  - If k≥`i_gold_count`: overflow, counted as an error at index k. k saturates at `i_gold_count`.
- `o_pass`=(err==0)&&!timeout, valid when `o_done`.
- `i_op_count`==0: FETCH is skipped and the FSM goes straight to DRAIN. If `i_gold_count` is also 0, done occurs 2 cycles after start with pass=1.

## Timing
- Reset values:
  - FSM in IDLE.
  - All valids, busy, done, pass and timeout are 0.
  - Counters and addresses are 0; `o_first_err` is all-ones.
- Reset mid-run aborts immediately. No partial status survives.
- `o_busy` rises the cycle after `i_start` and falls with `o_done`.
- First op is issued at the earliest 3 cycles after start: FETCH, WAIT_RDY sampling `i_op_ready`, then ISSUE.
- `i_in_ready` low stalls the stream with `o_in_valid` and `o_in_data` held stable.
- Timeout fires when `o_cycle_cnt` reaches MAX_CYCLE while not done:
  - Force DONE with timeout=1.
  - Stop the cycle count.
  - `o_err_cnt` keeps its current value.
- `i_out_valid` in the DONE cycle is ignored.
- The checker is independent of the issue FSM. Outputs arriving during LOAD are checked.

## Structure
- Package `core_pattern_pkg`: FSM state enum (IDLE, FETCH, WAIT_RDY, ISSUE, LOAD, NEXT, DRAIN, DONE), error-counter width, and the `FIRST_ERR_NONE` constant.
- Sub-module `core_stream_checker` holds k, the golden address, compare, error and overflow counting, and first-error capture. The top holds the issue FSM, stream indices, cycle counter and timeout.

## Test plan
- 2 ops {LOAD_MODE, 1}, LOAD_LEN=4, `i_in_ready` always 1, model core echoes 2 correct words:
  - 4 beats on 4 consecutive cycles.
  - done with pass=1, err=0, `o_first_err` all-ones.
- `i_in_ready` toggling 1010… during load: each beat is held until accepted; the sink sees in[0..3] in order with no duplicates.
- Golden mismatch at word 3 of 5: err=1, first_err=3, pass=0.
- `i_gold_count`=2, model emits 3 words: err=1 (overflow), first_err=2.
- `i_op_ready` never asserted, MAX_CYCLE=50:
  - done at cycle_cnt=50 with timeout=1, pass=0.
  - `o_op_valid` never high.
- `i_rst` asserted mid-LOAD, then restart: all outputs return to reset values next cycle, and the second run passes identically to the first.

Source files
------------

// File: rtl/core_pattern_pkg.sv
// Shared types and constants for the core pattern player and its stream checker.
// No logic here; the issue FSM and the checker both import it.
package core_pattern_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_RDY,
        ISSUE,
        LOAD,
        NEXT,
        DRAIN,
        DONE
    } state_t;

    localparam int ERR_W = 16;
    localparam int CYC_W = 32;

    // Truncated to the first-error width at each use; all-ones marks "no error yet".
    localparam logic [31:0] FIRST_ERR_NONE = '1;

endpackage

// File: rtl/core_stream_checker.sv
// Compares core results against golden ROM words; counts mismatches and overflow words.
// Golden address comes from next-state k so gold[k] is present the cycle a result arrives; never stalls the core.
module core_stream_checker
    import core_pattern_pkg::*;
#(
    parameter int OUT_W      = 14,
    parameter int GOLD_DEPTH = 4096
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            clear_i,
    input  logic                            en_i,
    input  logic                            out_vld_i,
    input  logic [OUT_W-1:0]                out_dat_i,
    input  logic [$clog2(GOLD_DEPTH+1)-1:0] gold_count_i,
    output logic [$clog2(GOLD_DEPTH)-1:0]   gold_addr_o,
    input  logic [OUT_W-1:0]                gold_dat_i,
    output logic [$clog2(GOLD_DEPTH+1)-1:0] k_o,
    output logic [ERR_W-1:0]                err_cnt_o,
    output logic [$clog2(GOLD_DEPTH+1)-1:0] first_err_o
);
    localparam int GC_W = $clog2(GOLD_DEPTH + 1);
    localparam int GA_W = $clog2(GOLD_DEPTH);
    localparam logic [GC_W-1:0] NONE = GC_W'(FIRST_ERR_NONE);

    logic [GC_W-1:0]  k_q, k_d;
    logic [ERR_W-1:0] err_cnt_q;
    logic [GC_W-1:0]  first_err_q;
    logic             err;

    always_comb begin
        k_d = k_q;
        err = 1'b0;
        if (rst_i || clear_i) begin
            k_d = '0;
        end else if (en_i && out_vld_i) begin
            if (k_q < gold_count_i) begin
                k_d = k_q + 1'b1;
                err = (out_dat_i != gold_dat_i);
            end else begin
                // k stays saturated; every extra word is an error at index gold_count
                err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            k_q         <= '0;
            err_cnt_q   <= '0;
            first_err_q <= NONE;
        end else begin
            k_q <= k_d;
            if (err) begin
                if (err_cnt_q != {ERR_W{1'b1}}) begin
                    err_cnt_q <= err_cnt_q + 1'b1;
                end
                if (first_err_q == NONE) begin
                    first_err_q <= k_q;
                end
            end
        end
    end

    assign gold_addr_o = k_d[GA_W-1:0];
    assign k_o         = k_q;
    assign err_cnt_o   = err_cnt_q;
    assign first_err_o = first_err_q;

endmodule

// File: rtl/core_pattern_player.sv
// Replays an op list and input feature maps into the core and checks its output stream; reports pass/fail.
// First op 3 cycles after start, loads stream 1 beat/cycle; i_in_ready low holds the beat stable.
module core_pattern_player
    import core_pattern_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int OP_W       = 4,
    parameter int OUT_W      = 14,
    parameter int LOAD_MODE  = 0,
    parameter int LOAD_LEN   = 2048,
    parameter int OP_DEPTH   = 1024,
    parameter int GOLD_DEPTH = 4096,
    parameter int MAX_CYCLE  = 4000
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_start,
    input  logic [$clog2(OP_DEPTH+1)-1:0]   i_op_count,
    input  logic [$clog2(GOLD_DEPTH+1)-1:0] i_gold_count,
    output logic [$clog2(OP_DEPTH)-1:0]     o_op_addr,
    input  logic [OP_W-1:0]                 i_op_rdata,
    output logic [$clog2(LOAD_LEN)-1:0]     o_in_addr,
    input  logic [DATA_W-1:0]               i_in_rdata,
    output logic [$clog2(GOLD_DEPTH)-1:0]   o_gold_addr,
    input  logic [OUT_W-1:0]                i_gold_rdata,
    output logic                            o_op_valid,
    output logic [OP_W-1:0]                 o_op_mode,
    input  logic                            i_op_ready,
    output logic                            o_in_valid,
    output logic [DATA_W-1:0]               o_in_data,
    input  logic                            i_in_ready,
    input  logic                            i_out_valid,
    input  logic [OUT_W-1:0]                i_out_data,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_pass,
    output logic                            o_timeout,
    output logic [ERR_W-1:0]                o_err_cnt,
    output logic [$clog2(GOLD_DEPTH+1)-1:0] o_first_err,
    output logic [CYC_W-1:0]                o_cycle_cnt
);
    localparam int OPC_W = $clog2(OP_DEPTH + 1);
    localparam int OPA_W = $clog2(OP_DEPTH);
    localparam int INA_W = $clog2(LOAD_LEN);
    localparam int GC_W  = $clog2(GOLD_DEPTH + 1);
    localparam logic [INA_W-1:0] J_LAST = INA_W'(LOAD_LEN - 1);

    state_t            state_q;
    logic [OPC_W-1:0]  i_q;
    logic [INA_W-1:0]  j_q, j_d;
    logic              op_valid_q, in_valid_q, busy_q, done_q, timeout_q;
    logic [OP_W-1:0]   op_mode_q;
    logic [CYC_W-1:0]  cycle_q;
    logic [GC_W-1:0]   k;
    logic              start_acc, drain_done, tmo;

    assign start_acc  = i_start && (state_q == IDLE || state_q == DONE);
    assign drain_done = (k == i_gold_count);
    // A run finishing naturally on the last allowed cycle is not a timeout
    assign tmo = busy_q && (cycle_q + 32'd1 == 32'(MAX_CYCLE))
              && !(state_q == DRAIN && drain_done);

    // Stream index drives the input ROM directly so in[j] is present during its beat
    always_comb begin
        j_d = j_q;
        if (i_rst || start_acc) begin
            j_d = '0;
        end else if (state_q == LOAD && i_in_ready) begin
            j_d = (j_q == J_LAST) ? '0 : j_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            i_q        <= '0;
            j_q        <= '0;
            op_valid_q <= 1'b0;
            op_mode_q  <= '0;
            in_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            cycle_q    <= '0;
        end else begin
            j_q <= j_d;
            if (busy_q) begin
                cycle_q <= cycle_q + 1'b1;
            end
            case (state_q)
                IDLE, DONE: begin
                    state_q <= IDLE;
                    if (i_start) begin
                        state_q   <= (i_op_count == '0) ? DRAIN : FETCH;
                        i_q       <= '0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        timeout_q <= 1'b0;
                        cycle_q   <= 32'd1;
                    end
                end
                FETCH: state_q <= WAIT_RDY;
                WAIT_RDY: begin
                    if (i_op_ready) begin
                        state_q    <= ISSUE;
                        op_valid_q <= 1'b1;
                        op_mode_q  <= i_op_rdata;
                    end
                end
                ISSUE: begin
                    op_valid_q <= 1'b0;
                    if (op_mode_q == OP_W'(LOAD_MODE)) begin
                        state_q    <= LOAD;
                        in_valid_q <= 1'b1;
                    end else begin
                        state_q <= NEXT;
                    end
                end
                LOAD: begin
                    if (i_in_ready && j_q == J_LAST) begin
                        in_valid_q <= 1'b0;
                        state_q    <= NEXT;
                    end
                end
                NEXT: begin
                    i_q     <= i_q + 1'b1;
                    state_q <= (i_q + 1'b1 == i_op_count) ? DRAIN : FETCH;
                end
                DRAIN: begin
                    if (drain_done) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (tmo) begin
                state_q    <= DONE;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
                timeout_q  <= 1'b1;
                op_valid_q <= 1'b0;
                in_valid_q <= 1'b0;
            end
        end
    end

    core_stream_checker #(
        .OUT_W      (OUT_W),
        .GOLD_DEPTH (GOLD_DEPTH)
    ) u_checker (
        .clk_i        (i_clk),
        .rst_i        (i_rst),
        .clear_i      (start_acc),
        .en_i         (busy_q),
        .out_vld_i    (i_out_valid),
        .out_dat_i    (i_out_data),
        .gold_count_i (i_gold_count),
        .gold_addr_o  (o_gold_addr),
        .gold_dat_i   (i_gold_rdata),
        .k_o          (k),
        .err_cnt_o    (o_err_cnt),
        .first_err_o  (o_first_err)
    );

    assign o_op_addr   = i_q[OPA_W-1:0];
    assign o_in_addr   = j_d;
    assign o_op_valid  = op_valid_q;
    assign o_op_mode   = op_mode_q;
    assign o_in_valid  = in_valid_q;
    assign o_in_data   = in_valid_q ? i_in_rdata : '0;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_timeout   = timeout_q;
    assign o_pass      = done_q && (o_err_cnt == '0) && !timeout_q;
    assign o_cycle_cnt = cycle_q;

endmodule
